// File: rtl/recuperacao_memoria_pkg.sv
// rtl/recuperacao_memoria_pkg.sv - shared state encoding and default sizes for recuperacao_memoria
// Contents: estado_t (OCIOSO/NAVEGANDO/ENTREGA), default PROFUNDIDADE and LARGURA.
package recuperacao_memoria_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    NAVEGANDO = 2'b01,
    ENTREGA   = 2'b10
  } estado_t;

  localparam int PROFUNDIDADE_PADRAO = 4;
  localparam int LARGURA_PADRAO      = 8;

endpackage

// File: rtl/recuperacao_memoria_if.sv
// rtl/recuperacao_memoria_if.sv - result bus between memory controller, history block and ULA operand mux
// Signals: carregar/resultado_entrada (write side), operando_recuperado/operando_valido (delivery side).
// master = memory controller / operand consumer, slave = recuperacao_memoria.
interface recuperacao_memoria_if
  import recuperacao_memoria_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
);
  logic               carregar;
  logic [LARGURA-1:0] resultado_entrada;
  logic [LARGURA-1:0] operando_recuperado;
  logic               operando_valido;

  modport master (
    output carregar, resultado_entrada,
    input  operando_recuperado, operando_valido
  );

  modport slave (
    input  carregar, resultado_entrada,
    output operando_recuperado, operando_valido
  );
endinterface

// File: rtl/recuperacao_memoria_detector_borda.sv
// rtl/recuperacao_memoria_detector_borda.sv - rising-edge detector for one level button
// Ports: clk, rst (sync, active-high), sinal_i (button level), evento_o (high in the first cycle of a press).
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic sinal_i,
  output logic evento_o
);
  logic sinal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sinal_q <= 1'b0;
    end else begin
      sinal_q <= sinal_i;
    end
  end

  assign evento_o = sinal_i & ~sinal_q;
endmodule

// File: rtl/recuperacao_memoria.sv
// rtl/recuperacao_memoria.sv - circular history of ULA results with button browsing and operand delivery
// Ports: clk, rst (sync, active-high); bus (slave: carregar, resultado_entrada, operando_recuperado,
// operando_valido); btn_recuperar/btn_confirmar/btn_cancelar (level buttons); navegando, indice,
// valor_exibido, vazio (display/status). Macro HISTORICO_LIMPAR_EN adds btn_limpar (clear history).
module recuperacao_memoria
  import recuperacao_memoria_pkg::*;
#(
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int LARGURA      = LARGURA_PADRAO,
  localparam int AW          = $clog2(PROFUNDIDADE),
  localparam int CW          = AW + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  recuperacao_memoria_if.slave bus,
  input  logic                 btn_recuperar,
  input  logic                 btn_confirmar,
  input  logic                 btn_cancelar,
`ifdef HISTORICO_LIMPAR_EN
  input  logic                 btn_limpar,
`endif
  output logic                 navegando,
  output logic [AW-1:0]        indice,
  output logic [LARGURA-1:0]   valor_exibido,
  output logic                 vazio
);
  logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
  logic [AW-1:0]      wr_ptr_q;
  logic [CW-1:0]      count_q;
  logic [AW-1:0]      indice_q;
  estado_t            estado_q;
  logic               navegando_q;
  logic               valido_q;
  logic [LARGURA-1:0] operando_q;

  logic ev_rec, ev_conf, ev_can, ev_lim;

  detector_borda u_borda_rec  (.clk(clk), .rst(rst), .sinal_i(btn_recuperar), .evento_o(ev_rec));
  detector_borda u_borda_conf (.clk(clk), .rst(rst), .sinal_i(btn_confirmar), .evento_o(ev_conf));
  detector_borda u_borda_can  (.clk(clk), .rst(rst), .sinal_i(btn_cancelar),  .evento_o(ev_can));
`ifdef HISTORICO_LIMPAR_EN
  detector_borda u_borda_lim  (.clk(clk), .rst(rst), .sinal_i(btn_limpar),    .evento_o(ev_lim));
`else
  assign ev_lim = 1'b0;
`endif

  // Newest entry sits just behind the write pointer; indice counts backwards from it.
  logic [AW-1:0]      rd_addr;
  logic [LARGURA-1:0] exibido;
  assign rd_addr = wr_ptr_q - AW'(1) - indice_q;
  assign exibido = mem_q[rd_addr];

  // Browse step first (wrapping within valid entries), then a same-cycle write shifts the age by one.
  logic [AW-1:0] indice_passo;
  logic          sobrescreve;
  always_comb begin
    indice_passo = indice_q;
    if (ev_rec) begin
      indice_passo = (({1'b0, indice_q} + CW'(1)) < count_q) ? indice_q + AW'(1) : '0;
    end
    sobrescreve = bus.carregar && (indice_passo == AW'(PROFUNDIDADE - 1)) &&
                  (count_q == CW'(PROFUNDIDADE));
  end

  // Storage is never reset; only entries covered by count_q are ever displayed.
  always_ff @(posedge clk) begin
    if (bus.carregar && !ev_lim) begin
      mem_q[wr_ptr_q] <= bus.resultado_entrada;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      indice_q    <= '0;
      estado_q    <= OCIOSO;
      navegando_q <= 1'b0;
      valido_q    <= 1'b0;
      operando_q  <= '0;
    end else if (ev_lim) begin
      // Clear drops any same-cycle write and keeps the last delivered operand.
      wr_ptr_q    <= '0;
      count_q     <= '0;
      indice_q    <= '0;
      estado_q    <= OCIOSO;
      navegando_q <= 1'b0;
      valido_q    <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      if (bus.carregar) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (count_q != CW'(PROFUNDIDADE)) begin
          count_q <= count_q + CW'(1);
        end
      end
      case (estado_q)
        OCIOSO: begin
          if (ev_rec && count_q != '0) begin
            estado_q    <= NAVEGANDO;
            navegando_q <= 1'b1;
            indice_q    <= '0;
          end
        end
        NAVEGANDO: begin
          if (ev_can) begin
            estado_q    <= OCIOSO;
            navegando_q <= 1'b0;
            indice_q    <= '0;
          end else if (ev_conf) begin
            // Memory write is non-blocking, so this captures the pre-write entry.
            estado_q    <= ENTREGA;
            navegando_q <= 1'b0;
            indice_q    <= '0;
            operando_q  <= exibido;
            valido_q    <= 1'b1;
          end else if (sobrescreve) begin
            // The displayed (oldest) entry is being overwritten: abandon browsing.
            estado_q    <= OCIOSO;
            navegando_q <= 1'b0;
            indice_q    <= '0;
          end else if (bus.carregar) begin
            indice_q <= indice_passo + AW'(1);
          end else begin
            indice_q <= indice_passo;
          end
        end
        ENTREGA: begin
          estado_q <= OCIOSO;
        end
        default: begin
          estado_q    <= OCIOSO;
          navegando_q <= 1'b0;
          indice_q    <= '0;
        end
      endcase
    end
  end

  assign bus.operando_recuperado = operando_q;
  assign bus.operando_valido     = valido_q;
  assign navegando               = navegando_q;
  assign indice                  = indice_q;
  assign valor_exibido           = navegando_q ? exibido : '0;
  assign vazio                   = (count_q == '0);
endmodule

// File: tb/tb_recuperacao_memoria.sv
// tb/tb_recuperacao_memoria.sv - self-checking bench for recuperacao_memoria (table, directed, random vs model)
module tb_recuperacao_memoria;
  localparam int P = 4;
  localparam int L = 8;

  logic clk;
  logic rst;
  logic btn_recuperar, btn_confirmar, btn_cancelar;
`ifdef HISTORICO_LIMPAR_EN
  logic btn_limpar;
`endif
  logic         navegando;
  logic [1:0]   indice;
  logic [L-1:0] valor_exibido;
  logic         vazio;

  recuperacao_memoria_if #(.LARGURA(L)) bus ();

  recuperacao_memoria #(.PROFUNDIDADE(P), .LARGURA(L)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .btn_recuperar(btn_recuperar), .btn_confirmar(btn_confirmar), .btn_cancelar(btn_cancelar),
`ifdef HISTORICO_LIMPAR_EN
    .btn_limpar(btn_limpar),
`endif
    .navegando(navegando), .indice(indice), .valor_exibido(valor_exibido), .vazio(vazio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: history as a queue, newest at the front; state 0=idle, 1=browsing, 2=delivering.
  logic [L-1:0] hist[$];
  int           m_st, m_idx;
  logic [L-1:0] m_op;
  bit           m_vld;
  bit           p_rec, p_conf, p_can, p_lim;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  task automatic modelo(input bit c, input logic [L-1:0] d, input bit rec, input bit conf,
                        input bit can, input bit lim, input bit r);
    bit e_rec, e_conf, e_can, e_lim;
    int s;
    if (r) begin
      hist.delete(); m_st = 0; m_idx = 0; m_op = '0; m_vld = 0;
      p_rec = 0; p_conf = 0; p_can = 0; p_lim = 0;
      return;
    end
    e_rec = rec && !p_rec; e_conf = conf && !p_conf; e_can = can && !p_can; e_lim = lim && !p_lim;
    p_rec = rec; p_conf = conf; p_can = can; p_lim = lim;
    m_vld = 0;
    if (e_lim) begin
      hist.delete(); m_st = 0; m_idx = 0;
      return;
    end
    s = m_st;
    if (s == 2) m_st = 0;
    else if (s == 0) begin
      if (e_rec && hist.size() > 0) begin m_st = 1; m_idx = 0; end
    end else if (e_can) begin
      m_st = 0; m_idx = 0;
    end else if (e_conf) begin
      m_op = hist[m_idx]; m_vld = 1; m_st = 2; m_idx = 0;
    end else begin
      if (e_rec) m_idx = (m_idx + 1 < hist.size()) ? m_idx + 1 : 0;
      if (c) begin
        if (m_idx == P - 1 && hist.size() == P) begin m_st = 0; m_idx = 0; end
        else m_idx++;
      end
    end
    if (c) begin
      hist.push_front(d);
      if (hist.size() > P) void'(hist.pop_back());
    end
  endtask

  task automatic step(input bit c, input logic [L-1:0] d, input bit rec, input bit conf,
                      input bit can, input bit lim, input bit r);
    logic [L-1:0] e_val;
    @(negedge clk);
    bus.carregar = c; bus.resultado_entrada = d;
    btn_recuperar = rec; btn_confirmar = conf; btn_cancelar = can; rst = r;
`ifdef HISTORICO_LIMPAR_EN
    btn_limpar = lim;
`endif
    @(posedge clk);
    modelo(c, d, rec, conf, can, lim, r);
    #1;
    e_val = (m_st == 1) ? hist[m_idx] : '0;
    check("modelo.navegando", 32'(navegando), 32'(m_st == 1));
    check("modelo.indice", 32'(indice), 32'(m_idx));
    check("modelo.valor_exibido", 32'(valor_exibido), 32'(e_val));
    check("modelo.operando_valido", 32'(bus.operando_valido), 32'(m_vld));
    check("modelo.operando_recuperado", 32'(bus.operando_recuperado), 32'(m_op));
    check("modelo.vazio", 32'(vazio), 32'(hist.size() == 0));
  endtask

  typedef struct {
    bit c; logic [L-1:0] d; bit rec, conf, can;
    bit nav; int idx; logic [L-1:0] val; bit vld; logic [L-1:0] op; bit vz;
  } vec_t;
  vec_t tab[$];

  int pulsos;

  initial begin
    bus.carregar = 0; bus.resultado_entrada = '0;
    btn_recuperar = 0; btn_confirmar = 0; btn_cancelar = 0; rst = 1;
`ifdef HISTORICO_LIMPAR_EN
    btn_limpar = 0;
`endif
    step(0, 0, 0, 0, 0, 0, 1);
    check("reset.vazio", 32'(vazio), 32'd1);
    check("reset.navegando", 32'(navegando), 32'd0);

    //              c  d     rec conf can  nav idx val   vld op    vz
    tab.push_back('{0, 8'h00, 1, 0, 0,     0, 0, 8'h00, 0, 8'h00, 1}); // recuperar on empty history
    tab.push_back('{0, 8'h00, 0, 0, 0,     0, 0, 8'h00, 0, 8'h00, 1});
    tab.push_back('{1, 8'h11, 0, 0, 0,     0, 0, 8'h00, 0, 8'h00, 0});
    tab.push_back('{1, 8'h22, 0, 0, 0,     0, 0, 8'h00, 0, 8'h00, 0});
    tab.push_back('{1, 8'h33, 0, 0, 0,     0, 0, 8'h00, 0, 8'h00, 0});
    tab.push_back('{0, 8'h00, 1, 0, 0,     1, 0, 8'h33, 0, 8'h00, 0});
    tab.push_back('{0, 8'h00, 0, 0, 0,     1, 0, 8'h33, 0, 8'h00, 0});
    tab.push_back('{0, 8'h00, 1, 0, 0,     1, 1, 8'h22, 0, 8'h00, 0});
    tab.push_back('{0, 8'h00, 0, 0, 0,     1, 1, 8'h22, 0, 8'h00, 0});
    tab.push_back('{0, 8'h00, 0, 1, 0,     0, 0, 8'h00, 1, 8'h22, 0}); // delivery one cycle after confirm
    tab.push_back('{0, 8'h00, 0, 0, 0,     0, 0, 8'h00, 0, 8'h22, 0});
    for (int i = 1; i <= 4; i++)
      tab.push_back('{1, 8'(i), 0, 0, 0,   0, 0, 8'h00, 0, 8'h22, 0});
    for (int i = 0; i < 5; i++) begin       // wrap 0,1,2,3,0
      tab.push_back('{0, 8'h00, 1, 0, 0,   1, i % 4, 8'(4 - (i % 4)), 0, 8'h22, 0});
      tab.push_back('{0, 8'h00, 0, 0, 0,   1, i % 4, 8'(4 - (i % 4)), 0, 8'h22, 0});
    end
    tab.push_back('{0, 8'h00, 1, 0, 0,     1, 1, 8'h03, 0, 8'h22, 0});
    tab.push_back('{0, 8'h00, 0, 0, 0,     1, 1, 8'h03, 0, 8'h22, 0});
    tab.push_back('{1, 8'h05, 0, 0, 0,     1, 2, 8'h03, 0, 8'h22, 0}); // write while browsing tracks entry
    tab.push_back('{0, 8'h00, 1, 0, 0,     1, 3, 8'h02, 0, 8'h22, 0});
    tab.push_back('{0, 8'h00, 0, 0, 0,     1, 3, 8'h02, 0, 8'h22, 0});
    tab.push_back('{1, 8'h06, 0, 0, 0,     0, 0, 8'h00, 0, 8'h22, 0}); // displayed entry overwritten
    tab.push_back('{0, 8'h00, 0, 0, 0,     0, 0, 8'h00, 0, 8'h22, 0});

    foreach (tab[i]) begin
      step(tab[i].c, tab[i].d, tab[i].rec, tab[i].conf, tab[i].can, 0, 0);
      check($sformatf("tab[%0d].navegando", i), 32'(navegando), 32'(tab[i].nav));
      check($sformatf("tab[%0d].indice", i), 32'(indice), 32'(tab[i].idx));
      check($sformatf("tab[%0d].valor_exibido", i), 32'(valor_exibido), 32'(tab[i].val));
      check($sformatf("tab[%0d].operando_valido", i), 32'(bus.operando_valido), 32'(tab[i].vld));
      check($sformatf("tab[%0d].operando_recuperado", i), 32'(bus.operando_recuperado), 32'(tab[i].op));
      check($sformatf("tab[%0d].vazio", i), 32'(vazio), 32'(tab[i].vz));
    end

    // cancelar and confirmar in the same cycle: cancel wins, no delivery
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    check("simult.navegando", 32'(navegando), 32'd0);
    check("simult.valido", 32'(bus.operando_valido), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("simult.valido_apos", 32'(bus.operando_valido), 32'd0);

    // holding confirmar yields exactly one delivery
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    pulsos = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 0, 0, 0);
      pulsos += int'(bus.operando_valido);
    end
    check("hold_confirmar.pulsos", 32'(pulsos), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);

    // reset while browsing
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_nav.navegando", 32'(navegando), 32'd0);
    check("rst_nav.vazio", 32'(vazio), 32'd1);
    check("rst_nav.operando", 32'(bus.operando_recuperado), 32'd0);

    // reset while delivering
    step(1, 8'h5A, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("entrega.valido", 32'(bus.operando_valido), 32'd1);
    check("entrega.operando", 32'(bus.operando_recuperado), 32'h5A);
    step(0, 0, 0, 0, 0, 0, 1);
    check("rst_entrega.valido", 32'(bus.operando_valido), 32'd0);
    check("rst_entrega.operando", 32'(bus.operando_recuperado), 32'd0);
    check("rst_entrega.vazio", 32'(vazio), 32'd1);

`ifdef HISTORICO_LIMPAR_EN
    step(1, 8'h77, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 8'h44, 0, 0, 0, 1, 0);
    check("limpar.vazio", 32'(vazio), 32'd1);
    check("limpar.operando", 32'(bus.operando_recuperado), 32'h77);
    step(0, 0, 0, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      bit lim;
`ifdef HISTORICO_LIMPAR_EN
      lim = ($urandom_range(0, 99) == 0);
`else
      lim = 0;
`endif
      step($urandom_range(0, 2) == 0, 8'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           lim, $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/recuperacao_memoria.md
Name: recuperacao_memoria

Overview:
Read-side companion to the result-storage path: keeps a short circular history of ULA results written by the memory-load strobe. Lets the user browse past results with push-buttons and deliver the chosen one as a ULA operand. Sits between the memory controller (load strobe and result) and the ULA operand multiplexer. Drives the display while the user is browsing.

Parameters:
PROFUNDIDADE, 4, number of history entries (power of two, >=2)
LARGURA, 8, data width of stored results

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
carregar  input  1  write strobe (memory-load signal), one entry per high cycle
resultado_entrada  input  LARGURA  value written when carregar=1
btn_recuperar  input  1  level button: step to older entry
btn_confirmar  input  1  level button: deliver displayed entry
btn_cancelar  input  1  level button: leave browse mode
operando_recuperado  output  LARGURA  last delivered value, registered
operando_valido  output  1  one-cycle pulse with each delivery
navegando  output  1  high while in NAVEGANDO
indice  output  $clog2(PROFUNDIDADE)  age of displayed entry, 0 = newest
valor_exibido  output  LARGURA  entry at indice (0 when not browsing)
vazio  output  1  history holds no entries

Behaviour:
- Reset (rst=1 at a clock edge): write pointer=0, count=0, FSM=OCIOSO, indice=0, operando_recuperado=0, operando_valido=0, navegando=0, valor_exibido=0, vazio=1, button history regs=0. Storage contents need not be cleared. Reset is honoured in any state, including mid-browse and mid-delivery.
- Buttons: each is sampled into a register. A press event is btn & ~btn_q, evaluated in cycle T. Holding a button yields exactly one event.
- Write side, every cycle carregar=1:
  - mem[wr_ptr] <= resultado_entrada; wr_ptr increments modulo PROFUNDIDADE.
  - count increments and saturates at PROFUNDIDADE.
  - Writes are accepted in all FSM states.
- Read address = (wr_ptr - 1 - indice) mod PROFUNDIDADE.
- FSM states: OCIOSO, NAVEGANDO, ENTREGA.
  - OCIOSO, recuperar event with count>0 -> NAVEGANDO, indice=0. With count=0 the event is ignored.
  - NAVEGANDO, recuperar event -> indice+1 if indice+1<count, else wrap to 0.
  - NAVEGANDO, confirmar event -> ENTREGA; operando_recuperado <= displayed entry.
  - NAVEGANDO, cancelar event -> OCIOSO; indice=0.
  - ENTREGA -> OCIOSO unconditionally after one cycle; operando_valido=1 only in ENTREGA.
- Delivery latency: confirm event in cycle T gives operando_valido=1 and the new operando_recuperado in cycle T+1. operando_recuperado holds until the next delivery.
- Simultaneous button events in one cycle: cancelar > confirmar > recuperar; only the highest-priority event acts.
- Write during NAVEGANDO (not in the same cycle as confirmar):
  - indice increments, so the same physical entry stays displayed.
  - If indice was PROFUNDIDADE-1 with count=PROFUNDIDADE, that entry is overwritten: FSM -> OCIOSO, indice=0, no delivery.
- Write in the same cycle as confirmar: the captured value is the one displayed before the write.
- navegando=1 exactly in NAVEGANDO. vazio = (count==0).

Optional Feature:
HISTORICO_LIMPAR_EN
- Defined: adds input btn_limpar (level, edge-detected the same way as the other buttons). A press event sets count=0, wr_ptr=0, indice=0 and FSM=OCIOSO.
  - Priority: above all buttons, below rst.
  - A carregar in the same cycle is dropped.
  - operando_recuperado is kept.
- Undefined: port absent; history is cleared only by rst.

Decomposition:
- Shared package: FSM state encoding (OCIOSO=2'b00, NAVEGANDO=2'b01, ENTREGA=2'b10); default PROFUNDIDADE and LARGURA constants.
- One sub-module, detector_borda: 1-bit registered rising-edge detector with synchronous active-high reset, instantiated once per button.

Test Plan:
- Reset, then recuperar press with empty history -> state stays OCIOSO, navegando=0, vazio=1, operando_valido never pulses.
- Write 0x11, 0x22, 0x33; recuperar, recuperar, confirmar -> valor_exibido 0x33 then 0x22; operando_recuperado=0x22 with a one-cycle operando_valido, in the cycle after the confirm event.
- Fill 4 entries (0x01..0x04), press recuperar 5 times -> indice 0,1,2,3,0; valor_exibido 0x04,0x03,0x02,0x01,0x04.
- Browse to indice=1 (0x03), pulse carregar with 0x05 -> indice=2, valor_exibido stays 0x03. Browse to indice=3 with a full buffer, then write -> returns to OCIOSO, no operando_valido.
- cancelar and confirmar rising in the same cycle -> OCIOSO, no delivery. Hold confirmar 10 cycles -> exactly one operando_valido pulse.
- rst asserted in ENTREGA or NAVEGANDO -> all outputs at reset values on the next cycle. With HISTORICO_LIMPAR_EN, limpar press -> vazio=1 and operando_recuperado keeps its previous value.
